serial_subtractor_unit: RTL and testbench



---
 rtl/serial_subtractor_unit.sv | 87 ++++++++
 tb/tb_serial_subtractor_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_unit.sv
// Bit-serial subtractor: D = A - B, LSB first, one full-subtractor step per clock.
// Valid/ready operand port in front, valid/ready result port behind; no operand queueing.
module serial_subtractor_unit #(
  parameter int W = 8
) (
  input  logic         CK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow_out,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  sa, sb, dr, dr_nxt;
  logic          br, bit_d, br_nxt;
  logic [CW-1:0] cnt;
  logic          last;

  // One full-subtractor cell working on the current LSBs.
  always_comb begin
    bit_d  = sa[0] ^ sb[0] ^ br;
    br_nxt = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
    dr_nxt = dr >> 1;
    dr_nxt[W-1] = bit_d;
    last   = (cnt == CW'(W - 1));
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      dr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (in_valid) begin
          sa  <= a_in;
          sb  <= b_in;
          dr  <= '0;
          br  <= 1'b0;
          cnt <= '0;
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          dr  <= dr_nxt;
          br  <= br_nxt;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode state only; result outputs are the raw registers.
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign diff       = dr;
  assign borrow_out = br;

endmodule

// File: tb/tb_serial_subtractor_unit.sv
// Self-checking bench for serial_subtractor_unit at W=8 and W=1: directed cases,
// backpressure, mid-operation reset and a randomized sweep against an arithmetic model.
module tb_serial_subtractor_unit;

  logic       ck = 1'b0;
  logic       rst;
  int         checks = 0;
  int         failures = 0;

  logic       iv8, ir8, ov8, or8, bo8, busy8;
  logic [7:0] a8, b8, d8;
  logic       iv1, ir1, ov1, or1, bo1, busy1;
  logic [0:0] a1, b1, d1;

  always #5 ck = ~ck;

  serial_subtractor_unit #(.W(8)) dut8 (
    .CK(ck), .RST(rst), .in_valid(iv8), .in_ready(ir8), .a_in(a8), .b_in(b8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow_out(bo8), .busy(busy8)
  );

  serial_subtractor_unit #(.W(1)) dut1 (
    .CK(ck), .RST(rst), .in_valid(iv1), .in_ready(ir1), .a_in(a1), .b_in(b1),
    .out_valid(ov1), .out_ready(or1), .diff(d1), .borrow_out(bo1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full W=8 operation: accept, measure latency, check result, hold for `hold`
  // cycles of backpressure (optionally poking in_valid), then release.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int hold, input bit poke);
    logic [7:0] ed;
    logic       eb;
    int         lat;
    ed = 8'(a - b);
    eb = (a < b);
    iv8 = 1'b1; a8 = a; b8 = b;
    check("w8_in_ready_idle", 32'(ir8), 32'd1);
    @(posedge ck); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (!ov8 && lat < 40) begin
      or8 = 1'($urandom_range(0, 1));
      @(posedge ck); #1;
      lat++;
    end
    or8 = 1'b0;
    check("w8_latency", 32'(lat), 32'd8);
    check("w8_diff", 32'(d8), 32'(ed));
    check("w8_borrow", 32'(bo8), 32'(eb));
    check("w8_invariant", 32'(8'(d8 + b)), 32'(a));
    for (int i = 0; i < hold; i++) begin
      iv8 = poke; a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge ck); #1;
      check("w8_hold_valid", 32'(ov8), 32'd1);
      check("w8_hold_diff", 32'(d8), 32'(ed));
      check("w8_hold_borrow", 32'(bo8), 32'(eb));
      check("w8_hold_in_ready", 32'(ir8), 32'd0);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge ck); #1;
    or8 = 1'b0;
    check("w8_release_valid", 32'(ov8), 32'd0);
    check("w8_release_in_ready", 32'(ir8), 32'd1);
  endtask

  task automatic op1(input logic a, input logic b, input int hold);
    int lat;
    iv1 = 1'b1; a1 = a; b1 = b;
    @(posedge ck); #1;
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 10) begin
      or1 = 1'($urandom_range(0, 1));
      @(posedge ck); #1;
      lat++;
    end
    or1 = 1'b0;
    check("w1_latency", 32'(lat), 32'd1);
    check("w1_diff", 32'(d1), 32'((a ^ b) & 1'b1));
    check("w1_borrow", 32'(bo1), 32'(a < b));
    for (int i = 0; i < hold; i++) begin
      @(posedge ck); #1;
      check("w1_hold_valid", 32'(ov1), 32'd1);
    end
    or1 = 1'b1;
    @(posedge ck); #1;
    or1 = 1'b0;
    check("w1_release_busy", 32'(busy1), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    iv8 = 1'b1; a8 = 8'h55; b8 = 8'hAA; or8 = 1'b1;
    iv1 = 1'b1; a1 = 1'b0; b1 = 1'b1; or1 = 1'b1;
    repeat (2) @(posedge ck);
    #1;
    check("rst_out_valid", 32'(ov8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_diff", 32'(d8), 32'd0);
    check("rst_borrow", 32'(bo8), 32'd0);
    check("rst_in_ready", 32'(ir8), 32'd1);
    check("rst_w1_busy", 32'(busy1), 32'd0);
    iv8 = 1'b0; or8 = 1'b0; iv1 = 1'b0; or1 = 1'b0;
    @(negedge ck);
    rst = 1'b0;
    @(posedge ck); #1;
    check("post_rst_idle", 32'(busy8), 32'd0);

    // Directed results.
    op8(8'h05, 8'h03, 0, 1'b0);
    op8(8'h03, 8'h05, 0, 1'b0);
    op8(8'h00, 8'h01, 0, 1'b0);
    op8(8'hFF, 8'hFF, 0, 1'b0);

    // Backpressure with in_valid poked during DONE; the pokes must not be queued.
    op8(8'h07, 8'h09, 5, 1'b1);
    @(posedge ck); #1;
    check("bp_no_queued_op", 32'(busy8), 32'd0);

    // Reset in the middle of RUN.
    iv8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
    @(posedge ck); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    check("mid_run_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(ov8), 32'd0);
    check("mid_rst_busy", 32'(busy8), 32'd0);
    @(negedge ck);
    rst = 1'b0;
    @(posedge ck); #1;
    op8(8'h10, 8'h01, 0, 1'b0);

    // Randomized sweep.
    for (int n = 0; n < 1000; n++)
      op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    for (int n = 0; n < 300; n++)
      op1(1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
